// File: rtl/avalon_st_err_pkg.sv
// rtl/avalon_st_err_pkg.sv - shared constants and FSM state type for the Avalon-ST error checker
package avalon_st_err_pkg;
  // Checker-generated error bits sit directly above the mapped source bits.
  localparam int ERR_SOP_VIOL_OFS = 0;
  localparam int ERR_ORPHAN_OFS   = 1;
  localparam int ERR_OVERFLOW_OFS = 2;

  localparam int ERR_CNT_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;
endpackage

// File: rtl/avalon_st_skid_buffer.sv
// rtl/avalon_st_skid_buffer.sv - generic 2-entry skid buffer with registered in_ready
module avalon_st_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         push;
  logic         pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = head;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // in_ready is a flop so the upstream path never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
      head <= in_data;
    end else if (pop && count == 2'd2) begin
      head <= tail;
    end
    if (push && count == 2'd1 && !pop) begin
      tail <= in_data;
    end
  end
endmodule

// File: rtl/avalon_st_error_checker_reg.sv
// rtl/avalon_st_error_checker_reg.sv - registered Avalon-ST forwarder adding protocol and length error bits
module avalon_st_error_checker_reg
  import avalon_st_err_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int EMPTY_W     = 2,
  parameter int IN_ERR_W    = 1,
  parameter int MAX_BEATS   = 1024,
  parameter int STICKY_ERR  = 1,
  parameter int DROP_ORPHAN = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic [EMPTY_W-1:0]    in_empty,
  input  logic [IN_ERR_W-1:0]   in_error,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [EMPTY_W-1:0]    out_empty,
  output logic [IN_ERR_W+2:0]   out_error,
  output logic [ERR_CNT_W-1:0]  err_count
);
  localparam int OUT_ERR_W = IN_ERR_W + 3;
  localparam int PW        = DATA_W + EMPTY_W + OUT_ERR_W + 2;
  localparam int CNT_W     = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [IN_ERR_W-1:0]   acc_q;
  logic [IN_ERR_W-1:0]   acc_next;
  logic [IN_ERR_W-1:0]   acc_eff;
  logic [IN_ERR_W-1:0]   mapped;
  logic [OUT_ERR_W-1:0]  err_bits;
  logic                  accept;
  logic                  orphan;
  logic                  sop_viol;
  logic                  overflow;
  logic                  any_gen;
  logic                  drop;
  logic [PW-1:0]         wr_payload;
  logic [PW-1:0]         rd_payload;

  assign accept   = in_valid & in_ready;
  assign orphan   = (state == IDLE) & ~in_startofpacket;
  assign sop_viol = (state == IN_PKT) & in_startofpacket;
  assign any_gen  = sop_viol | orphan | overflow;
  assign drop     = (DROP_ORPHAN != 0) & orphan;

  // An orphan never touches packet state; everything else advances the length/sticky trackers.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc_q;
    acc_eff    = (in_startofpacket ? '0 : acc_q) | in_error;
    mapped     = in_error;
    overflow   = 1'b0;
    if (!orphan) begin
      if (in_startofpacket) begin
        cnt_next = CNT_W'(1);
      end else if (cnt != CNT_SAT) begin
        cnt_next = cnt + CNT_W'(1);
      end
      overflow   = (cnt_next == CNT_SAT);
      state_next = in_endofpacket ? IDLE : IN_PKT;
      acc_next   = in_endofpacket ? '0 : acc_eff;
      if (STICKY_ERR != 0) begin
        mapped = in_endofpacket ? acc_eff : '0;
      end
    end
  end

  always_comb begin
    err_bits                               = '0;
    err_bits[IN_ERR_W-1:0]                 = mapped;
    err_bits[IN_ERR_W + ERR_SOP_VIOL_OFS]  = sop_viol;
    err_bits[IN_ERR_W + ERR_ORPHAN_OFS]    = orphan;
    err_bits[IN_ERR_W + ERR_OVERFLOW_OFS]  = overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_q     <= '0;
      err_count <= '0;
    end else if (accept) begin
      state <= state_next;
      cnt   <= cnt_next;
      acc_q <= acc_next;
      if (any_gen && err_count != '1) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign wr_payload = {in_data, in_startofpacket, in_endofpacket, in_empty, err_bits};
  assign {out_data, out_startofpacket, out_endofpacket, out_empty, out_error} = rd_payload;

  avalon_st_skid_buffer #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid & ~drop),
    .in_ready  (in_ready),
    .in_data   (wr_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (rd_payload)
  );
endmodule

// File: tb/tb_avalon_st_error_checker_reg.sv
// tb/tb_avalon_st_error_checker_reg.sv - directed self-checking bench for avalon_st_error_checker_reg
module tb_avalon_st_error_checker_reg;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        sop = 1'b0;
  logic        eop = 1'b0;
  logic [1:0]  in_empty = '0;
  logic [0:0]  in_error = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_sop, out_eop;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic [3:0]  out_error;
  logic [15:0] err_count;

  logic        in_ready_b, out_valid_b, out_sop_b, out_eop_b;
  logic [31:0] out_data_b;
  logic [1:0]  out_empty_b;
  logic [3:0]  out_error_b;
  logic [15:0] err_count_b;

  always #5 clk = ~clk;

  // Main DUT: sticky errors, forwarded orphans, short MAX_BEATS so overflow is reachable.
  avalon_st_error_checker_reg #(
    .DATA_W(32), .EMPTY_W(2), .IN_ERR_W(1), .MAX_BEATS(4), .STICKY_ERR(1), .DROP_ORPHAN(0)
  ) u_dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(sop), .in_endofpacket(eop), .in_empty(in_empty), .in_error(in_error),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty),
    .out_error(out_error), .err_count(err_count)
  );

  // Companion: pass-through errors, dropped orphans, default length limit.
  avalon_st_error_checker_reg #(
    .DATA_W(32), .EMPTY_W(2), .IN_ERR_W(1), .MAX_BEATS(1024), .STICKY_ERR(0), .DROP_ORPHAN(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .in_ready(in_ready_b), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(sop), .in_endofpacket(eop), .in_empty(in_empty), .in_error(in_error),
    .out_ready(out_ready), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_startofpacket(out_sop_b), .out_endofpacket(out_eop_b), .out_empty(out_empty_b),
    .out_error(out_error_b), .err_count(err_count_b)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [3:0]  err;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    acc_cyc[$];
  int    out_cyc[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    b_beats = 0;
  bit    rand_rdy = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t bus_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic beat_t cur_out();
    return {out_data, out_sop, out_eop, out_empty, out_error};
  endfunction

  // One clock: monitor at the falling edge, then move to just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (!reset) begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", cur_out(), bus_prev);
      end
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        got_q.push_back(cur_out());
        out_cyc.push_back(cyc);
      end
      if (out_valid_b && out_ready) b_beats++;
      stall_prev = out_valid && !out_ready;
      bus_prev   = cur_out();
    end else begin
      stall_prev = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp,
                      input logic er, input logic [3:0] xerr, input bit expect_out);
    int guard;
    bit ok;
    guard = 0;
    in_valid = 1'b1; in_data = d; sop = s; eop = e; in_empty = emp; in_error = er;
    if (expect_out) exp_q.push_back({d, s, e, emp, xerr});
    do begin
      ok = in_ready;
      step();
      guard++;
    end while (!ok && guard < 1000);
    chk("send_accepted", ok, 1);
  endtask

  task automatic pkt(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      send(base + i, i == 0, i == n - 1, (i == n - 1) ? 2'(i) : 2'd0, 1'b0, 4'b0000, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; sop = 1'b0; eop = 1'b0; in_error = '0;
    repeat (n) step();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
    exp_q.delete(); got_q.delete(); acc_cyc.delete(); out_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
    step();
    chk("rst_release_ready", in_ready, 1);
    chk("rst_release_valid", out_valid, 0);

    // Three clean 4-beat packets back to back at full rate.
    for (int p = 0; p < 3; p++) pkt(4, 32'h1000 * (p + 1));
    idle(4);
    chk("t1_accepts", acc_cyc.size(), 12);
    chk("t1_outputs", out_cyc.size(), 12);
    if (acc_cyc.size() == 12 && out_cyc.size() == 12) begin
      chk("t1_accept_span", acc_cyc[11] - acc_cyc[0], 11);
      chk("t1_latency_first", out_cyc[0] - acc_cyc[0], 1);
      chk("t1_latency_last", out_cyc[11] - acc_cyc[11], 1);
    end
    check_stream("t1_beat");
    chk("t1_err_count", err_count, 0);

    // Sticky: error on beat 2 surfaces on EOP; beat 5 also exceeds MAX_BEATS=4.
    send(32'hA1, 1, 0, 2'd0, 0, 4'b0000, 1);
    send(32'hA2, 0, 0, 2'd0, 1, 4'b0000, 1);
    send(32'hA3, 0, 0, 2'd0, 0, 4'b0000, 1);
    send(32'hA4, 0, 0, 2'd0, 0, 4'b0000, 1);
    send(32'hA5, 0, 1, 2'd3, 0, 4'b1001, 1);
    pkt(3, 32'hB0);
    idle(4);
    check_stream("t3_beat");
    chk("t3_err_count", err_count, 1);
    chk("t3_err_count_b", err_count_b, 0);

    // 6-beat packet: overflow on beats 5 and 6 only.
    for (int i = 1; i <= 6; i++)
      send(32'hC0 + i, i == 1, i == 6, 2'd0, 0, (i >= 5) ? 4'b1000 : 4'b0000, 1);
    idle(4);
    check_stream("t4_beat");
    chk("t4_err_count", err_count, 3);
    chk("t4_err_count_b", err_count_b, 0);

    // SOP inside an open packet, then an orphan carrying a source error.
    b_beats = 0;
    send(32'hD1, 1, 0, 2'd0, 0, 4'b0000, 1);
    send(32'hD2, 0, 0, 2'd0, 0, 4'b0000, 1);
    send(32'hD3, 1, 0, 2'd0, 0, 4'b0010, 1);
    send(32'hD4, 0, 1, 2'd1, 0, 4'b0000, 1);
    send(32'hD5, 0, 0, 2'd0, 1, 4'b0101, 1);
    idle(4);
    check_stream("t5_beat");
    chk("t5_err_count", err_count, 5);
    chk("t5_err_count_b", err_count_b, 2);
    chk("t5_beats_b", b_beats, 4);

    // 200 clean packets under random backpressure.
    rand_rdy = 1'b1;
    for (int p = 0; p < 200; p++) pkt($urandom_range(1, 4), $urandom);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(8);
    check_stream("t2_beat");
    chk("t2_err_count", err_count, 5);
    chk("t2_err_count_b", err_count_b, 2);

    // Reset mid-packet with both buffer entries full and the sink stalled.
    out_ready = 1'b0;
    send(32'hE1, 1, 0, 2'd0, 0, 4'b0000, 0);
    send(32'hE2, 0, 0, 2'd0, 0, 4'b0000, 0);
    in_valid = 1'b0;
    chk("t6_full_ready", in_ready, 0);
    chk("t6_full_valid", out_valid, 1);
    reset = 1'b1;
    step();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    reset = 1'b0;
    step();
    chk("t6_ready_back", in_ready, 1);
    chk("t6_err_count", err_count, 0);
    chk("t6_err_count_b", err_count_b, 0);
    out_ready = 1'b1;
    send(32'hF1, 1, 0, 2'd0, 0, 4'b0000, 1);
    send(32'hF2, 0, 1, 2'd2, 0, 4'b0000, 1);
    idle(4);
    check_stream("t6_beat");
    chk("t6_err_count_after", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/avalon_st_error_checker_reg.md
Name: avalon_st_error_checker_reg

Overview:
- Parametrised, registered successor to the pass-through Avalon-ST error adapter.
- Forwards an Avalon-ST packet stream through a 2-entry skid buffer, passes through the source's error bits, and adds checker-generated error bits for protocol violations and packet-length overflow.
- Optionally accumulates source error bits across a packet and reports them on the EOP beat.
- Sits between a packet source (e.g. an Ethernet MAC RX path) and a downstream sink in the Qsys fabric.

Parameters:
- DATA_W, 32, data bus width in bits.
- EMPTY_W, 2, empty field width; must be at least clog2(DATA_W/8).
- IN_ERR_W, 1, input error width; 1 minimum.
- MAX_BEATS, 1024, maximum legal beats per packet, SOP through EOP inclusive.
- STICKY_ERR, 1, 1 = OR in_error over the packet and present the result on the EOP beat; 0 = per-beat pass-through.
- DROP_ORPHAN, 0, 1 = discard beats arriving outside a packet; 0 = forward them with the orphan bit set.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_ready  out  1  sink ready.
- in_valid  in  1  source valid.
- in_data  in  DATA_W  payload.
- in_startofpacket  in  1  SOP.
- in_endofpacket  in  1  EOP.
- in_empty  in  EMPTY_W  empty symbols; meaningful on EOP only.
- in_error  in  IN_ERR_W  source error bits.
- out_ready  in  1  downstream ready.
- out_valid  out  1  output valid.
- out_data  out  DATA_W  payload.
- out_startofpacket  out  1  SOP.
- out_endofpacket  out  1  EOP.
- out_empty  out  EMPTY_W  empty symbols.
- out_error  out  IN_ERR_W+3  error bits; [IN_ERR_W-1:0] = mapped source errors, then SOP_VIOL, ORPHAN, OVERFLOW.
- err_count  out  16  saturating count of beats carrying any checker-generated bit.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset:
  - out_valid=0, in_ready=0 while reset is high; in_ready=1 the first cycle after reset deasserts.
  - Skid buffer emptied, state=IDLE, beat counter=0, sticky accumulator=0, err_count=0.
  - Reset mid-packet discards all buffered beats with no EOP emitted.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - in_ready is registered and equals "skid buffer not full".
  - Latency is 1 cycle from acceptance to out_valid.
  - Sustained throughput is 1 beat/cycle with out_ready=1.
  - While out_valid=1 and out_ready=0, out_* must hold stable.
  - in_ready drops only after the second entry fills; no beat is ever lost.
- FSM (advances on accepted beats only):
  - IDLE, SOP beat: counter=1. If EOP is also set (single-beat packet), stay IDLE; otherwise go to IN_PKT.
  - IDLE, non-SOP beat: this is an orphan. ORPHAN=1. If DROP_ORPHAN=1, the beat is not written to the buffer but is still counted in err_count. Stay IDLE.
  - IN_PKT, SOP beat: SOP_VIOL=1 on that beat, which starts a new packet; counter=1 and the sticky accumulator is cleared. The earlier packet is not terminated.
  - IN_PKT, EOP beat: go to IDLE.
  - IN_PKT, any other beat: counter increments.
- Overflow:
  - When counter would exceed MAX_BEATS, OVERFLOW=1 on that beat and on every following beat up to and including EOP.
  - The counter saturates at MAX_BEATS+1; no wrap-around.
- Sticky mode (STICKY_ERR=1):
  - The accumulator ORs in_error on every accepted in-packet beat.
  - The mapped source bits are 0 on non-EOP beats and equal accumulator | in_error on the EOP beat.
  - The accumulator clears after the EOP beat.
  - Orphan beats pass in_error through directly.
- Pass-through mode (STICKY_ERR=0): mapped source bits = in_error on every beat.
- err_count:
  - Increments by 1 per accepted beat with any of SOP_VIOL, ORPHAN or OVERFLOW set.
  - Saturates at 16'hFFFF.
  - A beat with several generated bits set counts once.
- Pass-through fields: out_empty and out_data are passed through unchanged, never modified.

Decomposition:
- Package avalon_st_err_pkg holds:
  - Bit-offset constants ERR_SOP_VIOL_OFS, ERR_ORPHAN_OFS, ERR_OVERFLOW_OFS (relative to IN_ERR_W).
  - The FSM state enum {IDLE, IN_PKT}.
  - The err_count width constant (16).
- Sub-module avalon_st_skid_buffer:
  - Generic 2-entry skid buffer parametrised by payload width.
  - Payload = data+sop+eop+empty+error.
  - Provides the registered in_ready.

Test Plan:
- Three 4-beat packets, out_ready=1, error-free → identical beats appear 1 cycle later, out_error=0, 12 consecutive accepted cycles, err_count=0.
- Random out_ready (50%) over 200 packets → output beat stream equals input, no drop/duplication, out_* stable while stalled.
- STICKY_ERR=1, 5-beat packet with in_error=1 on beat 2 only → out_error[0]=0 on beats 1-4, =1 on beat 5 (EOP); next packet is clean.
- MAX_BEATS=4, 6-beat packet → OVERFLOW set on beats 5 and 6 only, err_count=2.
- SOP at beat 3 of an open packet, then an orphan beat after EOP → SOP_VIOL on that beat; ORPHAN forwarded (DROP_ORPHAN=0) or absent from output (DROP_ORPHAN=1); err_count=2 either way.
- Reset asserted for 1 cycle mid-packet with 2 beats buffered and out_ready=0 → out_valid=0 the next cycle, in_ready=1 a cycle later, err_count=0, the next SOP is accepted cleanly with no SOP_VIOL.
